seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Scan controller for the board's two 4-digit 7-segment banks (LED0/DN0, LED1/DN1).
//   Accepts a 32-bit hex value from the CPU or debug logic over a valid/ready handshake.
//   Double-buffers the value and commits it only at frame boundaries, so a frame never tears.
//   Time-multiplexes the digits with a dwell/blank schedule and drives segment/digit-select pins directly.
// PARAMETERS
//   CLK_DIV        100000  clk cycles each digit is lit (dwell); legal range >= 1
//   BLANK_CYCLES   16      clk cycles all digits are off between digits (anti-ghosting); >= 1
// PORTS
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   enable      in   1   1 = scan running; 0 = display dark
//   upd_valid   in   1   upd_data is valid this cycle
//   upd_ready   out  1   pending buffer empty; upd_valid&&upd_ready = accept
//   upd_data    in   32  value to show; nibble 7 = leftmost digit of bank0
//   dp_mask     in   8   decimal point per digit; bit i pairs with nibble i; sampled with upd_data
//   blank_lead  in   1   1 = suppress leading-zero digits; sampled with upd_data
//   seg0        out  8   bank0 {DP,CG,CF,CE,CD,CC,CB,CA}, active-high
//   an0         out  4   bank0 digit select {K4,K3,K2,K1}, one-hot or 0, active-high
//   seg1        out  8   bank1 segments, same encoding as seg0
//   an1         out  4   bank1 digit select, same encoding as an0
//   frame_done  out  1   one-cycle pulse at each frame boundary
// BEHAVIOUR
//   Reset: seg0=seg1=0, an0=an1=0, frame_done=0, upd_ready=1, display reg=0, dp reg=0,
//     blank reg=0, pending empty, idx=0, counter=0, state=IDLE.
//   Mapping: bank0 K(idx+1) shows nibble 7-idx; bank1 K(idx+1) shows nibble 3-idx; idx 0..3.
//     Both banks scan in lockstep (same idx).
//   Hex decode, seg[6:0]:
//     0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//     8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//     seg[7] = dp bit of that digit.
//   FSM states IDLE, SHOW, BLANK:
//     IDLE: an=0, seg=0. Moves to SHOW (idx=0, counter=0) on the first edge with enable=1.
//     SHOW: an=onehot(idx). Stays CLK_DIV cycles, then BLANK.
//     BLANK: an=0, seg=0. Stays BLANK_CYCLES cycles. Then idx wraps (3->0), and the FSM returns to SHOW.
//   Frame boundary:
//     Last BLANK cycle with idx=3. frame_done=1 on the edge that re-enters SHOW with idx=0.
//     Frame length is 4*(CLK_DIV+BLANK_CYCLES) cycles.
//   All outputs are registered.
//     an/seg take their new value on the same edge that enters the new state.
//     Segment data always comes from the committed display reg, never from pending.
//   Handshake:
//     On valid&&ready, upd_data, dp_mask and blank_lead are captured into pending. upd_ready=0 from the next cycle.
//     Pending commits to the display regs at the frame-boundary edge (or the next edge while IDLE).
//     upd_ready returns to 1 on that same edge.
//     valid without ready is ignored; the source must hold it. No combinational ready->valid path.
//   Leading-zero blank:
//     Nibble i (i=7..1) is blanked when blank_lead=1 and all nibbles >= i are 0. Nibble 0 is never blanked.
//     A blanked digit has seg[6:0]=0; DP still follows dp_mask; an still asserts.
//   enable falling mid-scan: next edge -> IDLE; an=0, seg=0, idx=0, counter=0, no frame_done.
//     The pending buffer is retained and commits on the next IDLE edge.
//   rst mid-operation: all state returns to reset values immediately (async).
//     Any pending value is discarded.
// TESTING (CLK_DIV=4, BLANK_CYCLES=2; frame = 24 cycles)
//   1. Release rst, enable=1, no update:
//      -> an0 steps 0001,0,0010,0,0100,0,1000,0; each on 4 cycles, off 2.
//      -> seg0=seg1=3F while lit; frame_done pulses every 24 cycles.
//   2. upd_data=12345678, dp_mask=0, blank_lead=0, accepted mid-frame:
//      -> upd_ready=0 until the boundary; old digits stay until then.
//      -> next frame: bank0 shows 06,5B,4F,66 and bank1 shows 6D,7D,07,7F.
//   3. upd_data=0000_00A5, blank_lead=1, dp_mask=01:
//      -> bank0 seg=00 on all digits; bank1 seg=00,00,77,ED.
//   4. Two back-to-back updates (AAAA_AAAA then 5555_5555):
//      -> second held off (ready=0) until the boundary.
//      -> frame N+1 shows AAAA_AAAA; frame N+2 shows 5555_5555.
//   5. enable=0 during SHOW idx=2:
//      -> next edge an0=an1=0, seg=0, no frame_done; re-enable restarts at idx=0.
//   6. Assert rst while pending full and idx=3:
//      -> outputs 0 and upd_ready=1 immediately; after release the display shows 0 (pending dropped).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Scan controller for two 4-digit 7-segment banks. A 32-bit hex value arrives
//   over a valid/ready handshake and waits in a pending buffer. It is committed
//   to the display registers only at a frame boundary (or while idle), so a
//   frame never mixes old and new digits. Both banks scan in lockstep. Each
//   digit is lit for CLK_DIV cycles, then all digits are dark for BLANK_CYCLES.
//
//   Ports
//     clk, rst          system clock, asynchronous active-high reset
//     enable            1 = scanning, 0 = display dark
//     upd_valid/ready   handshake for upd_data/dp_mask/blank_lead
//     upd_data          nibble 7 = leftmost digit of bank0, nibble 0 = rightmost of bank1
//     dp_mask           decimal point per nibble
//     blank_lead        suppress leading-zero digits
//     seg0/an0          bank0 segments {DP,G..A} and digit select {K4..K1}, active-high
//     seg1/an1          bank1, same encoding
//     frame_done        one-cycle pulse when a new frame starts
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | scan stopped, all digits dark
//   SHOW  | digit idx lit on both banks for CLK_DIV cycles
//   BLANK | all digits dark for BLANK_CYCLES cycles
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lead,
    output logic [7:0]  seg0,
    output logic [3:0]  an0,
    output logic [7:0]  seg1,
    output logic [3:0]  an1,
    output logic        frame_done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [31:0]      r_disp, w_disp_nxt;
    logic [7:0]       r_dp, w_dp_nxt;
    logic             r_blank, w_blank_nxt;

    logic [31:0]      r_pend_data;
    logic [7:0]       r_pend_dp;
    logic             r_pend_blank;
    logic             r_upd_ready;

    logic [7:0]       r_seg0, r_seg1, w_seg0_nxt, w_seg1_nxt;
    logic [3:0]       r_an0, r_an1, w_an_nxt;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_boundary;
    logic             w_commit;
    logic [3:0]       w_nib [8];
    logic [7:0]       w_lz;
    logic [2:0]       w_i0, w_i1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // The pending buffer is full exactly when ready is low.
    assign w_accept   = upd_valid && r_upd_ready;
    assign w_boundary = (r_state == BLANK) && (r_cnt == '0) && (r_idx == 2'd3) && enable;
    assign w_commit   = !r_upd_ready && (w_boundary || (r_state == IDLE));

    // Segments are decoded from the value the display regs hold after this edge,
    // so the first digit of a frame already shows the freshly committed value.
    assign w_disp_nxt  = w_commit ? r_pend_data  : r_disp;
    assign w_dp_nxt    = w_commit ? r_pend_dp    : r_dp;
    assign w_blank_nxt = w_commit ? r_pend_blank : r_blank;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SHOW;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = CNT_W'(CLK_DIV - 1);
                end
                SHOW: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = CNT_W'(BLANK_CYCLES - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = SHOW;
                        w_idx_nxt   = r_idx + 2'd1;   // 3 wraps to 0
                        w_cnt_nxt   = CNT_W'(CLK_DIV - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Nibble i is a leading zero when it and every nibble above it are 0.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < 8; i++) begin
            w_nib[i] = w_disp_nxt[4*i +: 4];
        end
        for (int i = 1; i < 8; i++) begin
            w_lz[i] = w_blank_nxt && ((w_disp_nxt >> (4*i)) == 32'd0);
        end
    end

    // bank0 shows nibble 7-idx, bank1 nibble 3-idx.
    assign w_i0 = {1'b1, ~w_idx_nxt};
    assign w_i1 = {1'b0, ~w_idx_nxt};

    always_comb begin
        w_an_nxt   = 4'b0000;
        w_seg0_nxt = 8'h00;
        w_seg1_nxt = 8'h00;
        if (w_state_nxt == SHOW) begin
            w_an_nxt   = 4'b0001 << w_idx_nxt;
            w_seg0_nxt = {w_dp_nxt[w_i0], w_lz[w_i0] ? 7'h00 : hex7(w_nib[w_i0])};
            w_seg1_nxt = {w_dp_nxt[w_i1], w_lz[w_i1] ? 7'h00 : hex7(w_nib[w_i1])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_disp       <= 32'd0;
            r_dp         <= 8'd0;
            r_blank      <= 1'b0;
            r_pend_data  <= 32'd0;
            r_pend_dp    <= 8'd0;
            r_pend_blank <= 1'b0;
            r_upd_ready  <= 1'b1;
            r_seg0       <= 8'd0;
            r_seg1       <= 8'd0;
            r_an0        <= 4'd0;
            r_an1        <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_disp       <= w_disp_nxt;
            r_dp         <= w_dp_nxt;
            r_blank      <= w_blank_nxt;
            if (w_accept) begin
                r_pend_data  <= upd_data;
                r_pend_dp    <= dp_mask;
                r_pend_blank <= blank_lead;
                r_upd_ready  <= 1'b0;
            end else if (w_commit) begin
                r_upd_ready  <= 1'b1;
            end
            r_seg0       <= w_seg0_nxt;
            r_seg1       <= w_seg1_nxt;
            r_an0        <= w_an_nxt;
            r_an1        <= w_an_nxt;
            r_frame_done <= w_boundary;
        end
    end

    assign upd_ready  = r_upd_ready;
    assign seg0       = r_seg0;
    assign seg1       = r_seg1;
    assign an0        = r_an0;
    assign an1        = r_an1;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 2;
    localparam int FRAME   = 4 * (CLK_DIV + BLANK);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_data = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic        blank_lead = 1'b0;
    logic [7:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        frame_done;

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .dp_mask    (dp_mask),
        .blank_lead (blank_lead),
        .seg0       (seg0),
        .an0        (an0),
        .seg1       (seg1),
        .an1        (an1),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] s0;
        logic [7:0] s1;
    } digit_t;

    digit_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     chk_timing = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // s0s/s1s hold the four digits of a frame, idx 0 in the top byte.
    task automatic push_frame(input logic [31:0] s0s, input logic [31:0] s1s);
        digit_t d;
        for (int i = 0; i < 4; i++) begin
            d.an = 4'b0001 << i;
            d.s0 = s0s[31-8*i -: 8];
            d.s1 = s1s[31-8*i -: 8];
            exp_q.push_back(d);
        end
    endtask

    task automatic wait_frame_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * FRAME + 8; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done not seen within budget", name);
        end
    endtask

    // Monitor: every digit onset pops one expected digit; also checks dwell
    // length, darkness between digits and the frame_done period.
    logic [3:0] prev_an0 = 4'd0;
    int         lit_len = 0;
    int         cyc = 0;
    int         fd_cyc = 0;
    bit         fd_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_an0 = 4'd0;
            lit_len  = 0;
            fd_valid = 1'b0;
        end else begin
            cyc++;
            if (an0 != 4'd0 && prev_an0 == 4'd0) begin
                lit_len = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_digit: an0=%b seg0=%h an1=%b seg1=%h", an0, seg0, an1, seg1);
                end else begin
                    digit_t d;
                    d = exp_q.pop_front();
                    check("digit{an0,an1,seg0,seg1}", {8'd0, an0, an1, seg0, seg1},
                          {8'd0, d.an, d.an, d.s0, d.s1});
                end
            end else if (an0 != 4'd0) begin
                lit_len++;
            end else if (prev_an0 != 4'd0) begin
                if (chk_timing) begin
                    check("dwell_len", lit_len, CLK_DIV);
                    check("blank_dark{an1,seg0,seg1}", {12'd0, an1, seg0, seg1}, 32'd0);
                end
            end
            if (frame_done) begin
                if (chk_timing && fd_valid) check("frame_period", cyc - fd_cyc, FRAME);
                fd_cyc   = cyc;
                fd_valid = 1'b1;
            end
            if (!chk_timing) fd_valid = 1'b0;
            prev_an0 = an0;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_an0", an0, 0);
        check("rst_an1", an1, 0);
        check("rst_seg0", seg0, 0);
        check("rst_seg1", seg1, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_upd_ready", upd_ready, 1);

        // 1: free-running scan of the reset value 0
        rst = 1'b0;
        push_frame(32'h3F3F3F3F, 32'h3F3F3F3F);
        push_frame(32'h3F3F3F3F, 32'h3F3F3F3F);
        chk_timing = 1'b1;
        enable = 1'b1;
        wait_frame_done("t1_boundary");

        // 2: update mid-frame; old digits stay until the boundary
        repeat (5) @(negedge clk);
        upd_data = 32'h12345678; dp_mask = 8'h00; blank_lead = 1'b0; upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        check("t2_ready_low", upd_ready, 0);
        push_frame(32'h065B4F66, 32'h6D7D077F);
        repeat (10) @(negedge clk);
        check("t2_ready_still_low", upd_ready, 0);
        wait_frame_done("t2_boundary");
        check("t2_ready_back", upd_ready, 1);

        // 3: leading-zero blank with DP on nibble 0
        repeat (3) @(negedge clk);
        upd_data = 32'h000000A5; dp_mask = 8'h01; blank_lead = 1'b1; upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0; dp_mask = 8'h00; blank_lead = 1'b0;
        check("t3_ready_low", upd_ready, 0);
        push_frame(32'h00000000, 32'h000077ED);
        wait_frame_done("t3_boundary");
        check("t3_ready_back", upd_ready, 1);

        // 4: back-to-back updates, second held off until the boundary
        repeat (2) @(negedge clk);
        upd_data = 32'hAAAAAAAA; upd_valid = 1'b1;
        @(negedge clk);
        upd_data = 32'h55555555;
        push_frame(32'h77777777, 32'h77777777);
        push_frame(32'h6D6D6D6D, 32'h6D6D6D6D);
        @(negedge clk);
        check("t4_second_held", upd_ready, 0);
        wait_frame_done("t4_boundary1");
        check("t4_ready_at_boundary", upd_ready, 1);
        @(negedge clk);
        upd_valid = 1'b0;
        check("t4_second_taken", upd_ready, 0);
        wait_frame_done("t4_boundary2");
        check("t4_ready_back", upd_ready, 1);

        // 5: enable drops during SHOW idx=2
        repeat (13) @(negedge clk);
        chk_timing = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("t5_dark{an0,an1,seg0,seg1}", {8'd0, an0, an1, seg0, seg1}, 32'd0);
        check("t5_no_frame_done", frame_done, 0);
        void'(exp_q.pop_back());   // idx 3 of this frame never shows
        repeat (3) @(negedge clk);
        check("t5_still_dark", an0, 0);
        push_frame(32'h6D6D6D6D, 32'h6D6D6D6D);
        push_frame(32'h6D6D6D6D, 32'h6D6D6D6D);
        chk_timing = 1'b1;
        enable = 1'b1;
        wait_frame_done("t5_restart_boundary");

        // 6: reset while pending is full and idx=3
        repeat (2) @(negedge clk);
        upd_data = 32'hDEADBEEF; upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        check("t6_pending_full", upd_ready, 0);
        repeat (16) @(negedge clk);
        check("t6_idx3_lit", an0, 4'b1000);
        #2;
        chk_timing = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst{an0,an1,seg0,seg1}", {8'd0, an0, an1, seg0, seg1}, 32'd0);
        check("t6_rst_ready", upd_ready, 1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_frame(32'h3F3F3F3F, 32'h3F3F3F3F);
        push_frame(32'h3F3F3F3F, 32'h3F3F3F3F);
        chk_timing = 1'b1;
        enable = 1'b1;
        wait_frame_done("t6_boundary");
        repeat (20) @(negedge clk);
        chk_timing = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("all_digits_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
